// File: rtl/reg_file_sb_if.sv
// Bus between the ID/WB pipeline stages and the register file with busy scoreboard.
// The master drives indices, write data and reservations; the slave returns data and busy status.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] RS_ID;
  logic [ADDR_W-1:0] RT_ID;
  logic [DATA_W-1:0] Reg_RData1;
  logic [DATA_W-1:0] Reg_RData2;
  logic              Reg_Write;
  logic [ADDR_W-1:0] Reg_W_ID;
  logic [DATA_W-1:0] Reg_WData;
  logic              Rsv_En;
  logic [ADDR_W-1:0] Rsv_ID;
  logic              RS_Busy;
  logic              RT_Busy;
  logic              Rsv_Conflict;
  logic [ADDR_W:0]   Busy_Count;

  modport master (
    output RS_ID, RT_ID, Reg_Write, Reg_W_ID, Reg_WData, Rsv_En, Rsv_ID,
    input  Reg_RData1, Reg_RData2, RS_Busy, RT_Busy, Rsv_Conflict, Busy_Count
  );

  modport slave (
    input  RS_ID, RT_ID, Reg_Write, Reg_W_ID, Reg_WData, Rsv_En, Rsv_ID,
    output Reg_RData1, Reg_RData2, RS_Busy, RT_Busy, Rsv_Conflict, Busy_Count
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised GPR file: two registered read ports, one write port, optional write bypass,
// optional hardwired-zero R0 and a per-entry busy scoreboard with occupancy counter.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  reg_file_sb_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [DATA_W-1:0] rdata1_r;
  logic [DATA_W-1:0] rdata2_r;
  logic              conflict_r;
  logic [ADDR_W:0]   count_r;

  logic              wr_en_s;
  logic              rsv_en_s;
  logic [NREG-1:0]   wr_dec_s;
  logic [NREG-1:0]   rsv_dec_s;
  logic [NREG-1:0]   clr_dec_s;
  logic [NREG-1:0]   busy_nxt_s;
  logic              inc_s;
  logic              dec_s;
  logic              conflict_s;
  logic [ADDR_W:0]   count_nxt_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;
  logic              rs_busy_s;
  logic              rt_busy_s;

  // Qualify write/reservation enables and decode them to one-hot entry masks.
  always_comb begin
    wr_en_s   = 1'b0;
    rsv_en_s  = 1'b0;
    wr_dec_s  = {NREG{1'b0}};
    rsv_dec_s = {NREG{1'b0}};
    if (bus.Reg_Write == 1'b1) begin
      if (ZERO_R0 && (bus.Reg_W_ID == {ADDR_W{1'b0}})) begin
        wr_en_s = 1'b0;
      end else begin
        wr_en_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end
    if (bus.Rsv_En == 1'b1) begin
      if (ZERO_R0 && (bus.Rsv_ID == {ADDR_W{1'b0}})) begin
        rsv_en_s = 1'b0;
      end else begin
        rsv_en_s = 1'b1;
      end
    end else begin
      rsv_en_s = 1'b0;
    end
    // Index decode only happens under a qualified enable, so an unknown idle index stays harmless.
    if (wr_en_s) begin
      wr_dec_s[bus.Reg_W_ID] = 1'b1;
    end else begin
      wr_dec_s = {NREG{1'b0}};
    end
    if (rsv_en_s) begin
      rsv_dec_s[bus.Rsv_ID] = 1'b1;
    end else begin
      rsv_dec_s = {NREG{1'b0}};
    end
  end

  // Scoreboard next state: a reservation beats a same-entry write (new producer).
  always_comb begin
    clr_dec_s   = wr_dec_s & ~rsv_dec_s;
    busy_nxt_s  = (busy_r & ~clr_dec_s) | rsv_dec_s;
    inc_s       = |(rsv_dec_s & ~busy_r);
    dec_s       = |(clr_dec_s & busy_r);
    conflict_s  = |(rsv_dec_s & busy_r & ~wr_dec_s);
    count_nxt_s = count_r + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
  end

  // Read-port source selection: zero entry, then bypass, then stored value.
  always_comb begin
    rdata1_s = {DATA_W{1'b0}};
    rdata2_s = {DATA_W{1'b0}};
    if (ZERO_R0 && (bus.RS_ID == {ADDR_W{1'b0}})) begin
      rdata1_s = {DATA_W{1'b0}};
    end else if (BYPASS && wr_dec_s[bus.RS_ID]) begin
      rdata1_s = bus.Reg_WData;
    end else begin
      rdata1_s = regs_r[bus.RS_ID];
    end
    if (ZERO_R0 && (bus.RT_ID == {ADDR_W{1'b0}})) begin
      rdata2_s = {DATA_W{1'b0}};
    end else if (BYPASS && wr_dec_s[bus.RT_ID]) begin
      rdata2_s = bus.Reg_WData;
    end else begin
      rdata2_s = regs_r[bus.RT_ID];
    end
  end

  // Combinational busy status; with bypass an entry being released this cycle already reads free.
  always_comb begin
    rs_busy_s = 1'b0;
    rt_busy_s = 1'b0;
    if (BYPASS && clr_dec_s[bus.RS_ID]) begin
      rs_busy_s = 1'b0;
    end else begin
      rs_busy_s = busy_r[bus.RS_ID];
    end
    if (BYPASS && clr_dec_s[bus.RT_ID]) begin
      rt_busy_s = 1'b0;
    end else begin
      rt_busy_s = busy_r[bus.RT_ID];
    end
  end

  // Register array, read data, scoreboard and counter state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      busy_r     <= {NREG{1'b0}};
      rdata1_r   <= {DATA_W{1'b0}};
      rdata2_r   <= {DATA_W{1'b0}};
      conflict_r <= 1'b0;
      count_r    <= {(ADDR_W + 1){1'b0}};
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_dec_s[i]) begin
          regs_r[i] <= bus.Reg_WData;
        end
      end
      busy_r     <= busy_nxt_s;
      rdata1_r   <= rdata1_s;
      rdata2_r   <= rdata2_s;
      conflict_r <= conflict_s;
      count_r    <= count_nxt_s;
    end
  end

  assign bus.Reg_RData1   = rdata1_r;
  assign bus.Reg_RData2   = rdata2_r;
  assign bus.RS_Busy      = rs_busy_s;
  assign bus.RT_Busy      = rt_busy_s;
  assign bus.Rsv_Conflict = conflict_r;
  assign bus.Busy_Count   = count_r;
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8x16 GPR file.
- Provides NREG = 2**ADDR_W entries of DATA_W bits, two registered read ports and one write port on a single rising clock edge.
- Adds same-cycle write-to-read bypass, an optional hardwired-zero R0 and a per-entry busy scoreboard with an occupancy counter.
- Sits between ID (reads and reservations) and WB (writes) in the pipeline; used by hazard control for stalls.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register index width; NREG = 2**ADDR_W
- ZERO_R0, 0, 1 = entry 0 always reads 0 and ignores writes and reservations
- BYPASS, 1, 1 = a read of the entry being written in the same cycle returns Reg_WData

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- RS_ID  in  ADDR_W  read port 1 index
- RT_ID  in  ADDR_W  read port 2 index
- Reg_RData1  out  DATA_W  registered read data, port 1
- Reg_RData2  out  DATA_W  registered read data, port 2
- Reg_Write  in  1  write enable
- Reg_W_ID  in  ADDR_W  write index
- Reg_WData  in  DATA_W  write data
- Rsv_En  in  1  reserve (mark busy) entry Rsv_ID
- Rsv_ID  in  ADDR_W  reservation index
- RS_Busy  out  1  combinational busy status of RS_ID
- RT_Busy  out  1  combinational busy status of RT_ID
- Rsv_Conflict  out  1  registered one-cycle pulse: reservation hit an already-busy entry
- Busy_Count  out  ADDR_W+1  number of busy entries

Behaviour:
- Clocking: one clock, CLK; reset is synchronous and active-high on RST. No negedge logic.
- Reset (RST=1 at rising edge) takes priority over all other inputs. Next cycle:
  - all entries = 0, all busy bits = 0
  - Reg_RData1 = Reg_RData2 = 0
  - Rsv_Conflict = 0, Busy_Count = 0
- Asserting RST mid-operation discards any write or reservation presented in that cycle.
- Write: at an edge with Reg_Write=1, entry[Reg_W_ID] <= Reg_WData.
  - Ignored when ZERO_R0=1 and Reg_W_ID=0.
- Read: latency 1 cycle. At each edge, Reg_RDataN <= value selected from the pre-edge state, in priority order:
  1. 0, if ZERO_R0=1 and index=0
  2. Reg_WData, if BYPASS=1, Reg_Write=1 and Reg_W_ID=index
  3. entry[index] as held before the edge
- With BYPASS=0, a same-cycle write and read of the same entry returns the old value.
- Both ports may address the same entry; the same rule applies independently to each.
- Scoreboard: busy[i], one bit per entry.
  - Write with Reg_Write=1 clears busy[Reg_W_ID].
  - Rsv_En=1 sets busy[Rsv_ID].
  - Same edge, same index (Reg_W_ID=Rsv_ID): the reservation wins and busy stays 1 (a new producer).
  - With ZERO_R0=1, index 0 is never busy and reservations of 0 are ignored.
- RS_Busy = busy[RS_ID], RT_Busy = busy[RT_ID], both combinational.
  - With BYPASS=1, a busy bit being cleared by a write in the same cycle reads as 0.
- Rsv_Conflict: asserted for exactly the cycle after an accepted reservation whose target was already busy (WAW).
  - The reservation still applies.
  - The bit is not set if the same edge's write clears that entry.
- Busy_Count: equals the population count of busy at all times.
  - +1 when a reservation turns an entry 0→1.
  - -1 when a write turns an entry 1→0.
  - Net 0 when both events hit different entries in the same cycle.
  - Never wraps; maximum is NREG (or NREG-1 with ZERO_R0).
- Writing a non-busy entry is legal: data updates, busy and count unchanged.
- X on an index while the matching enable is 0 must not affect state.

Test Plan:
- Reset: write entry3=0x1234, then hold RST 1 cycle → Reg_RData1 for RS_ID=3 reads 0x0000; Busy_Count=0; RS_Busy=0.
- Write then read: write entry5=0xBEEF; next cycle RS_ID=5 → Reg_RData1=0xBEEF one cycle later. Entry 5 unchanged by writes to other indices.
- Bypass: entry2 holds 0x0001; same cycle Reg_Write=1, Reg_W_ID=2, Reg_WData=0x00AA, RS_ID=RT_ID=2 → both outputs = 0x00AA next cycle (BYPASS=1) or 0x0001 (BYPASS=0).
- ZERO_R0=1: write 0xFFFF to entry0 and Rsv_En on 0 → reads return 0x0000, RS_Busy=0, Busy_Count unchanged.
- Scoreboard: reserve 1, 4, 6 on consecutive cycles → Busy_Count = 1, 2, 3; then write 4 → Busy_Count=2, busy[4]=0. Reserve 1 again → Rsv_Conflict=1 for one cycle, Busy_Count stays 2.
- Simultaneous events: Reg_Write on 6 and Rsv_En on 6 in the same cycle → busy[6]=1, count unchanged, Rsv_Conflict=0. Then reserve all 8 entries (ADDR_W=3, ZERO_R0=0) → Busy_Count=8 with no wrap.
